raifes_dmi_arbiter: RTL and testbench

RAIFES_DMI_ARBITER -- requirements
Module: raifes_dmi_arbiter

---
 rtl/raifes_dmi_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_raifes_dmi_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raifes_dmi_arbiter.sv
// raifes_dmi_arbiter
//   Two-requester round-robin arbiter in front of a single Debug Module
//   Interface (DMI) port. A grant latches the winner's command, strobes the
//   DM for one cycle, waits for the DM to drop busy (or for the timeout),
//   then returns the response and a one-cycle ack to the owner only.
//
// Ports
//   clk, nreset                    clock, synchronous active-low reset
//   m0_req/addr/wdata/wen          requester 0 (JTAG DTM) command
//   m0_ack/rdata/error             requester 0 completion and response
//   m1_*                           requester 1 (secondary transport), same as m0
//   dmi_addr/wdata/wen, dmi_en     command and strobe to the Debug Module
//   dmi_rdata/error, dmi_dm_busy   Debug Module response and busy flag
//   grant_id                       owner of the current or last transaction
//
// TIMEOUT: WAIT cycles with busy high before a forced error response (1..1023).

`ifndef DMI_ADDR_WIDTH
`define DMI_ADDR_WIDTH 7
`endif
`ifndef DMI_WIDTH
`define DMI_WIDTH 32
`endif

module raifes_dmi_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       nreset,

    input  logic                       m0_req,
    input  logic [`DMI_ADDR_WIDTH-1:0] m0_addr,
    input  logic [`DMI_WIDTH-1:0]      m0_wdata,
    input  logic                       m0_wen,
    output logic                       m0_ack,
    output logic [`DMI_WIDTH-1:0]      m0_rdata,
    output logic                       m0_error,

    input  logic                       m1_req,
    input  logic [`DMI_ADDR_WIDTH-1:0] m1_addr,
    input  logic [`DMI_WIDTH-1:0]      m1_wdata,
    input  logic                       m1_wen,
    output logic                       m1_ack,
    output logic [`DMI_WIDTH-1:0]      m1_rdata,
    output logic                       m1_error,

    output logic [`DMI_ADDR_WIDTH-1:0] dmi_addr,
    output logic [`DMI_WIDTH-1:0]      dmi_wdata,
    output logic                       dmi_wen,
    output logic                       dmi_en,
    input  logic [`DMI_WIDTH-1:0]      dmi_rdata,
    input  logic                       dmi_error,
    input  logic                       dmi_dm_busy,

    output logic                       grant_id
);

    localparam int unsigned AW = `DMI_ADDR_WIDTH;
    localparam int unsigned DW = `DMI_WIDTH;
    localparam int unsigned CW = 10;
    // The counter is compared before incrementing, so WAIT lasts TIMEOUT cycles.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state, state_d;
    logic            last_grant, last_grant_d;
    logic            grant_d;
    logic [CW-1:0]   tcnt, tcnt_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdata_d;
    logic            wen_d, en_d;
    logic            ack0_d, ack1_d, err0_d, err1_d;
    logic [DW-1:0]   rd0_d, rd1_d;
    logic            win;
    logic            rsp_fire;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            tcnt       <= '0;
            dmi_addr   <= '0;
            dmi_wdata  <= '0;
            dmi_wen    <= 1'b0;
            dmi_en     <= 1'b0;
            m0_ack     <= 1'b0;
            m0_rdata   <= '0;
            m0_error   <= 1'b0;
            m1_ack     <= 1'b0;
            m1_rdata   <= '0;
            m1_error   <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            grant_id   <= grant_d;
            tcnt       <= tcnt_d;
            dmi_addr   <= addr_d;
            dmi_wdata  <= wdata_d;
            dmi_wen    <= wen_d;
            dmi_en     <= en_d;
            m0_ack     <= ack0_d;
            m0_rdata   <= rd0_d;
            m0_error   <= err0_d;
            m1_ack     <= ack1_d;
            m1_rdata   <= rd1_d;
            m1_error   <= err1_d;
        end
    end

    // Next-state, arbitration and response capture
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        grant_d      = grant_id;
        tcnt_d       = tcnt;
        addr_d       = dmi_addr;
        wdata_d      = dmi_wdata;
        wen_d        = dmi_wen;
        en_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rd0_d        = m0_rdata;
        err0_d       = m0_error;
        rd1_d        = m1_rdata;
        err1_d       = m1_error;
        win          = 1'b0;
        rsp_fire     = 1'b0;
        rsp_rdata    = dmi_rdata;
        rsp_err      = dmi_error;

        case (state)
            IDLE: begin
                if ((m0_req || m1_req) && !dmi_dm_busy) begin
                    // Tie goes to whoever was not granted last
                    win          = (m0_req && m1_req) ? ~last_grant : m1_req;
                    grant_d      = win;
                    last_grant_d = win;
                    addr_d       = win ? m1_addr  : m0_addr;
                    wdata_d      = win ? m1_wdata : m0_wdata;
                    wen_d        = win ? m1_wen   : m0_wen;
                    en_d         = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!dmi_dm_busy) begin
                    rsp_fire = 1'b1;
                end else if (tcnt == TO_LAST) begin
                    rsp_fire  = 1'b1;
                    rsp_rdata = '0;
                    rsp_err   = 1'b1;
                end else begin
                    tcnt_d = tcnt + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response lands on the owner only; ack is high for the RESP cycle
        if (rsp_fire) begin
            state_d = RESP;
            if (grant_id) begin
                rd1_d  = rsp_rdata;
                err1_d = rsp_err;
                ack1_d = 1'b1;
            end else begin
                rd0_d  = rsp_rdata;
                err0_d = rsp_err;
                ack0_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raifes_dmi_arbiter.sv
// Self-checking bench for raifes_dmi_arbiter: directed transactions push
// expected DM commands and acks into queues; a negedge monitor pops and
// compares whenever the DUT strobes dmi_en or an ack.

`ifndef DMI_ADDR_WIDTH
`define DMI_ADDR_WIDTH 7
`endif
`ifndef DMI_WIDTH
`define DMI_WIDTH 32
`endif

module tb_raifes_dmi_arbiter;

    localparam int unsigned AW = `DMI_ADDR_WIDTH;
    localparam int unsigned DW = `DMI_WIDTH;

    logic          clk;
    logic          nreset;
    logic          m0_req, m0_wen, m0_ack, m0_error;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_wen, m1_ack, m1_error;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] dmi_addr;
    logic [DW-1:0] dmi_wdata, dmi_rdata;
    logic          dmi_wen, dmi_en, dmi_error, dmi_dm_busy;
    logic          grant_id;

    raifes_dmi_arbiter #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .m0_req      (m0_req),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wen      (m0_wen),
        .m0_ack      (m0_ack),
        .m0_rdata    (m0_rdata),
        .m0_error    (m0_error),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wen      (m1_wen),
        .m1_ack      (m1_ack),
        .m1_rdata    (m1_rdata),
        .m1_error    (m1_error),
        .dmi_addr    (dmi_addr),
        .dmi_wdata   (dmi_wdata),
        .dmi_wen     (dmi_wen),
        .dmi_en      (dmi_en),
        .dmi_rdata   (dmi_rdata),
        .dmi_error   (dmi_error),
        .dmi_dm_busy (dmi_dm_busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wen;
        int            cyc;
    } cmd_exp_t;

    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } ack_exp_t;

    cmd_exp_t cmd_q[$];
    ack_exp_t ack_q[$];
    cmd_exp_t ce;
    ack_exp_t ae;

    int n_cmp = 0;
    int n_err = 0;
    int quota0 = 0;
    int quota1 = 0;

    logic [DW-1:0] sh_rd0, sh_rd1;
    logic          sh_er0, sh_er1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!nreset) begin
            sh_rd0 = '0;
            sh_rd1 = '0;
            sh_er0 = 1'b0;
            sh_er1 = 1'b0;
        end else begin
            if (dmi_en) begin
                if (cmd_q.size() == 0) begin
                    check("dmi_en_spurious", 64'(dmi_en), 64'(0));
                end else begin
                    ce = cmd_q.pop_front();
                    check("cmd_grant_id", 64'(grant_id), 64'(ce.id));
                    check("cmd_addr", 64'(dmi_addr), 64'(ce.addr));
                    check("cmd_wdata", 64'(dmi_wdata), 64'(ce.wdata));
                    check("cmd_wen", 64'(dmi_wen), 64'(ce.wen));
                    check("cmd_cycle", 64'(cyc), 64'(ce.cyc));
                end
            end
            if (m0_ack || m1_ack) begin
                check("ack_exclusive", 64'(m0_ack & m1_ack), 64'(0));
                if (ack_q.size() == 0) begin
                    check("ack_spurious", 64'({m0_ack, m1_ack}), 64'(0));
                end else begin
                    ae = ack_q.pop_front();
                    check("ack_owner", 64'(m1_ack), 64'(ae.id));
                    check("ack_cycle", 64'(cyc), 64'(ae.cyc));
                    if (ae.id == 0) begin
                        check("m0_rdata", 64'(m0_rdata), 64'(ae.rdata));
                        check("m0_error", 64'(m0_error), 64'(ae.err));
                        check("m1_rdata_held", 64'(m1_rdata), 64'(sh_rd1));
                        check("m1_error_held", 64'(m1_error), 64'(sh_er1));
                        sh_rd0 = ae.rdata;
                        sh_er0 = ae.err;
                    end else begin
                        check("m1_rdata", 64'(m1_rdata), 64'(ae.rdata));
                        check("m1_error", 64'(m1_error), 64'(ae.err));
                        check("m0_rdata_held", 64'(m0_rdata), 64'(sh_rd0));
                        check("m0_error_held", 64'(m0_error), 64'(sh_er0));
                        sh_rd1 = ae.rdata;
                        sh_er1 = ae.err;
                    end
                end
            end
        end
    end

    task automatic push_cmd(input int id, input logic [AW-1:0] a, input logic [DW-1:0] w,
                            input logic we, input int c);
        cmd_exp_t e;
        e.id = id; e.addr = a; e.wdata = w; e.wen = we; e.cyc = c;
        cmd_q.push_back(e);
    endtask

    task automatic push_ack(input int id, input logic [DW-1:0] r, input logic er, input int c);
        ack_exp_t e;
        e.id = id; e.rdata = r; e.err = er; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic drive(input int id, input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input logic we);
        if (id == 0) begin
            m0_addr = a; m0_wdata = w; m0_wen = we; m0_req = 1'b1;
        end else begin
            m1_addr = a; m1_wdata = w; m1_wen = we; m1_req = 1'b1;
        end
    endtask

    // Run until both queues drain; each requester drops req after its quota of acks
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((ack_q.size() != 0 || cmd_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            if (m0_ack) begin
                quota0--;
                if (quota0 <= 0) m0_req = 1'b0;
            end
            if (m1_ack) begin
                quota1--;
                if (quota1 <= 0) m1_req = 1'b0;
            end
            n++;
        end
        if (ack_q.size() != 0 || cmd_q.size() != 0) begin
            check("wait_budget_pending", 64'(ack_q.size() + cmd_q.size()), 64'(0));
            ack_q.delete();
            cmd_q.delete();
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_dmi_en", 64'(dmi_en), 64'(0));
        check("rst_dmi_wen", 64'(dmi_wen), 64'(0));
        check("rst_dmi_addr", 64'(dmi_addr), 64'(0));
        check("rst_dmi_wdata", 64'(dmi_wdata), 64'(0));
        check("rst_m0_ack", 64'(m0_ack), 64'(0));
        check("rst_m1_ack", 64'(m1_ack), 64'(0));
        check("rst_m0_rdata", 64'(m0_rdata), 64'(0));
        check("rst_m1_rdata", 64'(m1_rdata), 64'(0));
        check("rst_m0_error", 64'(m0_error), 64'(0));
        check("rst_m1_error", 64'(m1_error), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
    endtask

    initial begin
        int c;
        nreset = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wen = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wen = 1'b0;
        dmi_rdata = '0; dmi_error = 1'b0; dmi_dm_busy = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        nreset = 1'b1;

        // Simultaneous requests held: first tie to m0, then strict alternation
        @(negedge clk);
        c = cyc;
        dmi_rdata = 32'hA5A5_0001;
        drive(0, 7'h20, 32'h0, 1'b0);
        drive(1, 7'h21, 32'h0, 1'b0);
        quota0 = 2; quota1 = 2;
        push_cmd(0, 7'h20, 32'h0, 1'b0, c + 1);  push_ack(0, 32'hA5A5_0001, 1'b0, c + 3);
        push_cmd(1, 7'h21, 32'h0, 1'b0, c + 5);  push_ack(1, 32'hA5A5_0001, 1'b0, c + 7);
        push_cmd(0, 7'h20, 32'h0, 1'b0, c + 9);  push_ack(0, 32'hA5A5_0001, 1'b0, c + 11);
        push_cmd(1, 7'h21, 32'h0, 1'b0, c + 13); push_ack(1, 32'hA5A5_0001, 1'b0, c + 15);
        wait_done(40);

        // DM busy for 5 WAIT cycles, error on completion: ack 5 cycles late
        @(negedge clk);
        c = cyc;
        dmi_rdata = 32'h0BAD_F00D;
        drive(1, 7'h08, 32'h0, 1'b0);
        quota1 = 1;
        push_cmd(1, 7'h08, 32'h0, 1'b0, c + 1);
        push_ack(1, 32'h0BAD_F00D, 1'b1, c + 8);
        @(negedge clk);
        dmi_dm_busy = 1'b1;
        repeat (6) @(negedge clk);
        dmi_dm_busy = 1'b0;
        dmi_error = 1'b1;
        wait_done(20);
        dmi_error = 1'b0;

        // Busy stuck: forced error with zero rdata after 8 WAIT cycles
        @(negedge clk);
        c = cyc;
        dmi_rdata = 32'hDEAD_BEEF;
        drive(0, 7'h11, 32'h0, 1'b0);
        quota0 = 1;
        push_cmd(0, 7'h11, 32'h0, 1'b0, c + 1);
        push_ack(0, 32'h0, 1'b1, c + 10);
        @(negedge clk);
        dmi_dm_busy = 1'b1;
        wait_done(30);
        dmi_dm_busy = 1'b0;

        // Plain read: minimum latency after the timeout recovered
        @(negedge clk);
        c = cyc;
        dmi_rdata = 32'h1234_5678;
        drive(0, 7'h10, 32'h0, 1'b0);
        quota0 = 1;
        push_cmd(0, 7'h10, 32'h0, 1'b0, c + 1);
        push_ack(0, 32'h1234_5678, 1'b0, c + 3);
        wait_done(20);

        // Reset during WAIT: transaction abandoned, no ack
        @(negedge clk);
        c = cyc;
        dmi_rdata = 32'h5555_AAAA;
        drive(0, 7'h12, 32'h0, 1'b0);
        push_cmd(0, 7'h12, 32'h0, 1'b0, c + 1);
        @(negedge clk);
        dmi_dm_busy = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        m0_req = 1'b0;
        dmi_dm_busy = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        check("rst_cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        nreset = 1'b1;
        repeat (4) @(negedge clk);

        // m1 write, req dropped during ISSUE: still acked, command held after
        c = cyc;
        dmi_rdata = 32'h0000_0001;
        drive(1, 7'h04, 32'hCAFE_F00D, 1'b1);
        quota1 = 1;
        push_cmd(1, 7'h04, 32'hCAFE_F00D, 1'b1, c + 1);
        push_ack(1, 32'h0000_0001, 1'b0, c + 3);
        @(negedge clk);
        m1_req = 1'b0;
        wait_done(20);
        repeat (2) @(negedge clk);
        check("hold_dmi_addr", 64'(dmi_addr), 64'(7'h04));
        check("hold_dmi_wdata", 64'(dmi_wdata), 64'(32'hCAFE_F00D));
        check("hold_dmi_wen", 64'(dmi_wen), 64'(1));
        check("hold_grant_id", 64'(grant_id), 64'(1));
        check("idle_dmi_en", 64'(dmi_en), 64'(0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
